// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one registered 4-bit ALU stage.
// Define ALU_ARB_RR_EN for round-robin arbitration (default: req0 priority).
module alu_arbiter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [2:0] req0_op,
   input  logic [3:0] req0_a,
   input  logic [3:0] req0_b,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [2:0] req1_op,
   input  logic [3:0] req1_a,
   input  logic [3:0] req1_b,
   output logic       resp_valid,
   input  logic       resp_ready,
   output logic       resp_id,
   output logic [3:0] resp_y,
   output logic       resp_overflow,
   output logic       resp_carry,
   output logic       resp_zero
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0] state;
   logic [2:0] op_q;
   logic [3:0] a_q;
   logic [3:0] b_q;
   logic       id_q;
   logic       gnt0;
   logic       gnt1;
   logic       idle_ok;
   logic       accept;

`ifdef ALU_ARB_RR_EN
   logic ptr;

   // A lone valid requester wins; on contention the pointer decides.
   always_comb begin
      gnt0 = req0_valid && (!req1_valid || !ptr);
      gnt1 = req1_valid && (!req0_valid || ptr);
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         ptr <= 1'b0;
      else if (accept)
         ptr <= ~gnt1;
   end
`else
   always_comb begin
      gnt0 = req0_valid;
      gnt1 = req1_valid && !req0_valid;
   end
`endif

   assign idle_ok    = rst_n && (state == IDLE);
   assign req0_ready = idle_ok && gnt0;
   assign req1_ready = idle_ok && gnt1;
   assign accept     = req0_ready || req1_ready;

   logic       sub;
   logic       arith;
   logic [3:0] bb;
   logic [4:0] sum;
   logic [3:0] y;
   logic       ovf;

   always_comb begin
      sub   = (op_q == 3'b001) || (op_q == 3'b110);
      arith = (op_q == 3'b000) || (op_q == 3'b001);
      bb    = sub ? ~b_q : b_q;
      sum   = {1'b0, a_q} + {1'b0, bb} + {4'b0, sub};
      ovf   = (a_q[3] == bb[3]) && (sum[3] != a_q[3]);
      y     = 4'd0;
      unique case (op_q)
         3'b000:  y = sum[3:0];
         3'b001:  y = sum[3:0];
         3'b010:  y = ~a_q;
         3'b011:  y = a_q & b_q;
         3'b100:  y = a_q | b_q;
         3'b101:  y = a_q ^ b_q;
         3'b110:  y = {3'b0, sum[3]};
         3'b111:  y = {3'b0, a_q == b_q};
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         op_q          <= 3'd0;
         a_q           <= 4'd0;
         b_q           <= 4'd0;
         id_q          <= 1'b0;
         resp_valid    <= 1'b0;
         resp_id       <= 1'b0;
         resp_y        <= 4'd0;
         resp_overflow <= 1'b0;
         resp_carry    <= 1'b0;
         resp_zero     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q  <= req1_ready ? req1_op : req0_op;
                  a_q   <= req1_ready ? req1_a  : req0_a;
                  b_q   <= req1_ready ? req1_b  : req0_b;
                  id_q  <= req1_ready;
                  state <= EXEC;
               end
            end
            EXEC: begin
               resp_y        <= y;
               resp_carry    <= arith && sum[4];
               resp_overflow <= arith && ovf;
               resp_zero     <= (y == 4'd0);
               resp_id       <= id_q;
               resp_valid    <= 1'b1;
               state         <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, random model
// comparison, reset, backpressure and contention sequences.
module tb_alu_arbiter;

   logic       clk;
   logic       rst_n;
   logic       req0_valid, req0_ready;
   logic [2:0] req0_op;
   logic [3:0] req0_a, req0_b;
   logic       req1_valid, req1_ready;
   logic [2:0] req1_op;
   logic [3:0] req1_a, req1_b;
   logic       resp_valid, resp_ready, resp_id;
   logic [3:0] resp_y;
   logic       resp_overflow, resp_carry, resp_zero;

   int checks = 0;
   int failures = 0;

   alu_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_y(resp_y),
      .resp_overflow(resp_overflow), .resp_carry(resp_carry),
      .resp_zero(resp_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       id;
      logic [2:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] y;
      logic       c;
      logic       v;
      logic       z;
   } vec_t;

   task automatic chk(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Returns {y, carry, overflow, zero} from integer arithmetic.
   function automatic logic [6:0] model(input logic [2:0] op,
                                        input logic [3:0] a,
                                        input logic [3:0] b);
      int ia, ib, sa, sb, s, sv;
      logic [3:0] y;
      logic c, v;
      ia = int'(a);
      ib = int'(b);
      sa = (ia > 7) ? ia - 16 : ia;
      sb = (ib > 7) ? ib - 16 : ib;
      c = 1'b0;
      v = 1'b0;
      y = 4'd0;
      case (op)
         3'd0: begin
            s = ia + ib; y = 4'(s % 16); c = (s > 15);
            sv = sa + sb; v = (sv > 7) || (sv < -8);
         end
         3'd1: begin
            s = ia - ib; y = 4'((s + 16) % 16); c = (ia >= ib);
            sv = sa - sb; v = (sv > 7) || (sv < -8);
         end
         3'd2: y = 4'(15 - ia);
         3'd3: y = a & b;
         3'd4: y = a | b;
         3'd5: y = a ^ b;
         3'd6: y = (((ia - ib + 16) % 16) >= 8) ? 4'd1 : 4'd0;
         default: y = (ia == ib) ? 4'd1 : 4'd0;
      endcase
      return {y, c, v, (y == 4'd0)};
   endfunction

   task automatic drive(input logic id, input logic [2:0] op,
                        input logic [3:0] a, input logic [3:0] b);
      if (id) begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      end
   endtask

   task automatic run_cmd(input logic id, input logic [2:0] op,
                          input logic [3:0] a, input logic [3:0] b,
                          input logic [6:0] exp, input int stall);
      int n;
      logic [3:0] y_hold;
      @(negedge clk);
      resp_ready = (stall == 0);
      drive(id, op, a, b);
      #1;
      n = 0;
      while (!(id ? req1_ready : req0_ready) && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 20) begin
         chk("accept_timeout", 8'd1, 8'd0);
         req0_valid = 1'b0;
         req1_valid = 1'b0;
         return;
      end
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("exec_valid", {7'd0, resp_valid}, 8'd0);
      chk("exec_ready", {6'd0, req0_ready, req1_ready}, 8'd0);
      @(negedge clk);
      chk("resp_latency", {7'd0, resp_valid}, 8'd1);
      y_hold = resp_y;
      for (int i = 0; i < stall; i++) begin
         chk("stall_hold", {3'd0, resp_valid, resp_y},
             {3'd0, 1'b1, y_hold});
         chk("stall_ready", {6'd0, req0_ready, req1_ready}, 8'd0);
         @(negedge clk);
      end
      resp_ready = 1'b1;
      chk("resp_id", {7'd0, resp_id}, {7'd0, id});
      chk("resp_y", {4'd0, resp_y}, {4'd0, exp[6:3]});
      chk("resp_flags", {5'd0, resp_carry, resp_overflow, resp_zero},
          {5'd0, exp[2:0]});
      @(negedge clk);
      chk("resp_retire", {7'd0, resp_valid}, 8'd0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   vec_t vecs[10];
   logic [6:0] ex;
   logic [2:0] rop;
   logic [3:0] ra, rb;
   logic       rid;
   logic       got_ids[4];
   logic       saw1, multi;
   int         cnt, cyc;

   initial begin
      vecs[0] = '{1'b0, 3'b000, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 3'b001, 4'h5, 4'h5, 4'h0, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{1'b0, 3'b110, 4'h2, 4'h3, 4'h1, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 3'b011, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 3'b101, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{1'b0, 3'b010, 4'h5, 4'h0, 4'hA, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 3'b111, 4'h9, 4'h9, 4'h1, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{1'b0, 3'b100, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1};
      vecs[8] = '{1'b1, 3'b001, 4'h8, 4'h1, 4'h7, 1'b1, 1'b1, 1'b0};
      vecs[9] = '{1'b0, 3'b000, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1};

      rst_n = 1'b0;
      req0_valid = 1'b1; req0_op = 3'd0; req0_a = 4'd0; req0_b = 4'd0;
      req1_valid = 1'b1; req1_op = 3'd0; req1_a = 4'd0; req1_b = 4'd0;
      resp_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ready", {6'd0, req0_ready, req1_ready}, 8'd0);
      chk("rst_resp", {resp_valid, resp_id, resp_y, resp_carry,
          resp_overflow}, 8'd0);
      chk("rst_zero", {7'd0, resp_zero}, 8'd0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst_n = 1'b1;

      foreach (vecs[i])
         run_cmd(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b,
                 {vecs[i].y, vecs[i].c, vecs[i].v, vecs[i].z},
                 (i == 3) ? 5 : 0);

      for (int i = 0; i < 40; i++) begin
         rid = 1'($urandom_range(0, 1));
         rop = 3'($urandom_range(0, 7));
         ra  = 4'($urandom_range(0, 15));
         rb  = 4'($urandom_range(0, 15));
         run_cmd(rid, rop, ra, rb, model(rop, ra, rb),
                 int'($urandom_range(0, 2)));
      end

      // Reset while a response is pending discards it.
      @(negedge clk);
      resp_ready = 1'b0;
      drive(1'b0, 3'b000, 4'h3, 4'h4);
      @(negedge clk);
      req0_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_valid", {7'd0, resp_valid}, 8'd1);
      rst_n = 1'b0;
      drive(1'b0, 3'b000, 4'h1, 4'h1);
      #1;
      chk("rst_mid_ready", {6'd0, req0_ready, req1_ready}, 8'd0);
      @(negedge clk);
      chk("rst_mid_resp", {resp_valid, resp_id, resp_y, resp_carry,
          resp_overflow}, 8'd0);
      rst_n = 1'b1;
      req0_valid = 1'b0;
      run_cmd(1'b1, 3'b000, 4'h2, 4'h3, model(3'b000, 4'h2, 4'h3), 0);

      // Continuous contention from a fresh reset.
      pulse_reset();
      resp_ready = 1'b1;
      drive(1'b0, 3'b000, 4'h1, 4'h2);
      drive(1'b1, 3'b000, 4'h3, 4'h4);
      cnt = 0; cyc = 0; saw1 = 1'b0; multi = 1'b0;
      while (cnt < 4 && cyc < 40) begin
         @(negedge clk);
         #1;
         if (req1_ready) saw1 = 1'b1;
         if (req0_ready && req1_ready) multi = 1'b1;
         if (resp_valid) begin
            got_ids[cnt] = resp_id;
            cnt++;
         end
         cyc++;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("cont_count", 8'(cnt), 8'd4);
      chk("cont_one_ready", {7'd0, multi}, 8'd0);
      for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
         chk("cont_id", {7'd0, got_ids[i]}, {7'd0, 1'(i % 2)});
`else
         chk("cont_id", {7'd0, got_ids[i]}, 8'd0);
`endif
      end
`ifdef ALU_ARB_RR_EN
      chk("cont_req1_ready", {7'd0, saw1}, 8'd1);
`else
      chk("cont_req1_ready", {7'd0, saw1}, 8'd0);
`endif

      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=done");
      $fatal(1, "timeout");
   end

endmodule
